division: RTL and testbench

//   Sequential unsigned integer divider, restoring algorithm, one quotient bit per clock.

---
 rtl/division_pkg.sv | 8 +
 rtl/division_if.sv | 13 +
 rtl/division_step.sv | 15 +
 rtl/division.sv | 56 +++++
 tb/tb_division.sv | 137 +++++++++++++
 5 files changed

// File: rtl/division_pkg.sv
// division_pkg: shared types and constants for the restoring divider
package division_pkg;
   localparam int DIV_WIDTH = 32;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction
endpackage

// File: rtl/division_if.sv
// division_if: operand/result bundle for the divider
// ports: start, a, b (requester -> divider); q, r, busy, done (divider -> requester)
interface division_if import division_pkg::*; #(parameter int WIDTH = DIV_WIDTH);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             busy;
   logic             done;
   modport master (output start, a, b, input q, r, busy, done);
   modport slave  (input start, a, b, output q, r, busy, done);
endinterface

// File: rtl/division_step.sv
// division_step: one combinational restoring-division step
// ports: rem (partial remainder), msb (next dividend bit), dvs (divisor) -> rem_n, qbit
module division_step #(parameter int WIDTH = 32) (
   input  logic [WIDTH-1:0] rem,
   input  logic             msb,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_n,
   output logic             qbit
);
   // shifted remainder kept WIDTH+1 bits wide so large divisors never lose the top bit
   logic [WIDTH:0] sh;
   assign sh    = {rem, msb};
   assign qbit  = sh >= {1'b0, dvs};
   assign rem_n = qbit ? WIDTH'(sh - {1'b0, dvs}) : sh[WIDTH-1:0];
endmodule

// File: rtl/division.sv
// division: sequential unsigned restoring divider, one quotient bit per clock
// ports: clock, reset (sync, active-high); bus.slave carries start/a/b in and q/r/busy/done out
module division import division_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
   input logic       clock,
   input logic       reset,
   division_if.slave bus
);
   localparam int CW = cnt_w(WIDTH);
   state_t           state, state_n;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd, dvs, rem, quo, rem_n;
   logic             qbit;
   division_step #(.WIDTH(WIDTH)) u_step (
      .rem  (rem),
      .msb  (dvd[WIDTH-1]),
      .dvs  (dvs),
      .rem_n(rem_n),
      .qbit (qbit)
   );
   assign bus.busy = state == BUSY;
   always_comb begin
      state_n = state;
      state_n = state == IDLE ? (bus.start ? BUSY : IDLE) :
                state == BUSY ? (cnt == CW'(1) ? DONE : BUSY) : IDLE;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         dvd      <= '0;
         dvs      <= '0;
         rem      <= '0;
         quo      <= '0;
         bus.q    <= '0;
         bus.r    <= '0;
         bus.done <= 1'b0;
      end else begin
         state    <= state_n;
         bus.done <= state == DONE;
         if (state == IDLE && bus.start) begin
            dvd <= bus.a;
            dvs <= bus.b;
            rem <= '0;
            cnt <= CW'(WIDTH);
         end else if (state == BUSY) begin
            dvd <= dvd << 1;
            rem <= rem_n;
            quo <= {quo[WIDTH-2:0], qbit};
            cnt <= cnt - CW'(1);
         end else if (state == DONE) begin
            bus.q <= quo;
            bus.r <= rem;
         end
      end
   end
endmodule

// File: tb/tb_division.sv
// tb_division: scoreboard bench for the divider against a plain-arithmetic model
module tb_division;
   logic clock = 1'b0;
   logic reset;
   int   cyc = 0;
   int   nvec = 0;
   int   nerr = 0;
   typedef struct {logic [31:0] q; logic [31:0] r; int c;} exp_t;
   exp_t sb[$];
   division_if #(.WIDTH(32)) bus();
   division #(.WIDTH(32)) u_dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int c);
      exp_t e;
      e.q = (b == 0) ? 32'hFFFF_FFFF : a / b;
      e.r = (b == 0) ? a : a % b;
      e.c = c;
      return e;
   endfunction
   task automatic op(input logic [31:0] a, input logic [31:0] b, input int hold);
      bus.a = a;
      bus.b = b;
      bus.start = 1'b1;
      @(posedge clock); #1;
      sb.push_back(model(a, b, cyc + 33));
      repeat (hold - 1) begin
         @(posedge clock); #1;
      end
      bus.start = 1'b0;
   endtask
   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         if (bus.done) return;
      end
      chk("done_timeout", 32'd0, 32'd1);
   endtask
   always @(posedge clock) begin
      #1;
      if (!reset && bus.done) begin
         if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("q", bus.q, e.q);
            chk("r", bus.r, e.r);
            chk("latency", cyc, e.c);
         end
      end
   end
   initial begin
      reset = 1'b1;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_q", bus.q, 32'd0);
      chk("rst_r", bus.r, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      reset = 1'b0;
      op(32'd7, 32'd3, 19);
      wait_done();
      repeat (5) @(posedge clock);
      #1;
      chk("hold_q", bus.q, 32'd2);
      chk("hold_r", bus.r, 32'd1);
      op(32'hFFFF_FFFF, 32'd1, 1);
      wait_done();
      op(32'd5, 32'd9, 1);
      wait_done();
      op(32'd100, 32'd10, 1);
      wait_done();
      op(32'd1234, 32'd0, 1);
      wait_done();
      op(32'd0, 32'd5, 1);
      wait_done();
      op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1);
      wait_done();
      op(32'd1000, 32'd7, 1);
      bus.a = 32'd55;
      bus.b = 32'd2;
      repeat (3) @(posedge clock);
      #1;
      chk("busy_q_held", bus.q, 32'hFFFF_FFFF / 32'hFFFF_FFFF * 32'd0);
      wait_done();
      op(32'd50, 32'd6, 1);
      repeat (9) @(posedge clock);
      #1;
      chk("mid_busy", {31'd0, bus.busy}, 32'd1);
      reset = 1'b1;
      @(posedge clock); #1;
      sb.delete();
      chk("abort_q", bus.q, 32'd0);
      chk("abort_r", bus.r, 32'd0);
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_done", {31'd0, bus.done}, 32'd0);
      reset = 1'b0;
      op(32'd99, 32'd4, 1);
      wait_done();
      bus.a = 32'd77;
      bus.b = 32'd5;
      bus.start = 1'b1;
      @(posedge clock); #1;
      sb.push_back(model(32'd77, 32'd5, cyc + 33));
      sb.push_back(model(32'd77, 32'd5, cyc + 67));
      wait_done();
      wait_done();
      bus.start = 1'b0;
      for (int i = 0; i < 30; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         case (i % 4)
            0: b = 32'($urandom_range(1, 15));
            1: b = $urandom;
            2: b = $urandom >> $urandom_range(0, 31);
            default: b = (i % 8 == 3) ? 32'd0 : a + 32'($urandom_range(0, 3));
         endcase
         op(a, b, 1);
         wait_done();
      end
      repeat (40) @(posedge clock);
      #1;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
